rpn_ctrl: RTL and testbench

Sequencing controller for the RPN calculator operand stack.
- Accepts a stream of tokens (operands or operators) over a valid/ready handshake.
- Pushes operands onto the stack.
- For each operator: pops two operands, computes through a combinational ALU, pushes the result back and reports it.
- Sits between the token source and the operand stack; it is the only agent driving the stack's push, pop and data inputs.

---
 rtl/calc_pkg.sv | 24 ++
 rtl/calc_alu.sv | 24 ++
 rtl/rpn_ctrl.sv | 138 +++++++++++++
 tb/tb_rpn_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the RPN calculator controller and its ALU.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_ILL = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_EXEC,
    S_WRES
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU: y = a <op> b, with a the older stack operand.
// Results wrap to WIDTH bits; low bits of a product are sign-agnostic.
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = 36
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_ctrl.sv
// RPN sequencing controller: accepts tokens, drives the operand stack and
// runs pop/execute/push-back for each operator, with a sticky error flag.
module rpn_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_is_op,
  input  logic [1:0]       tok_op,
  input  logic [WIDTH-1:0] tok_data,
  output logic [WIDTH-1:0] stk_d,
  output logic             stk_push,
  output logic             stk_pop,
  input  logic [WIDTH-1:0] stk_q1,
  input  logic [WIDTH-1:0] stk_q2,
  input  logic [9:0]       stk_ptr,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic             clr_err
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] operand_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] result_reg;
  logic             err_reg;
  logic [1:0]       err_code_reg;
  logic [WIDTH-1:0] alu_y;

  logic             idle_ready;
  logic             load_operand;
  logic             load_op;
  logic             err_set;
  logic [1:0]       err_code_set;

  calc_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (stk_q2),
    .b  (stk_q1),
    .op (op_reg),
    .y  (alu_y)
  );

  always_comb begin
    state_next   = state_reg;
    idle_ready   = 1'b0;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    stk_d        = '0;
    result_valid = 1'b0;
    load_operand = 1'b0;
    load_op      = 1'b0;
    err_set      = 1'b0;
    err_code_set = ERR_NONE;
    case (state_reg)
      S_IDLE: begin
        idle_ready = 1'b1;
        if (tok_valid) begin
          // Rejected tokens are consumed in place so errors cost no cycles.
          if (!tok_is_op) begin
            if (stk_ptr < 10'(DEPTH - 1)) begin
              load_operand = 1'b1;
              state_next   = S_PUSH;
            end else begin
              err_set      = 1'b1;
              err_code_set = ERR_OVER;
            end
          end else if (tok_op == OP_ILL) begin
            err_set      = 1'b1;
            err_code_set = ERR_ILL;
          end else if (stk_ptr < 10'd2) begin
            err_set      = 1'b1;
            err_code_set = ERR_UNDER;
          end else begin
            load_op    = 1'b1;
            state_next = S_POP;
          end
        end
      end
      S_PUSH: begin
        stk_push   = 1'b1;
        stk_d      = operand_reg;
        state_next = S_IDLE;
      end
      S_POP: begin
        stk_pop    = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        state_next = S_WRES;
      end
      S_WRES: begin
        stk_push     = 1'b1;
        stk_d        = result_reg;
        result_valid = 1'b1;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Ready is held low while reset is asserted, even though state is IDLE.
  assign tok_ready = idle_ready && !reset;
  assign result    = result_reg;
  assign err       = err_reg;
  assign err_code  = err_code_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      operand_reg  <= '0;
      op_reg       <= 2'b00;
      result_reg   <= '0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
    end else begin
      state_reg <= state_next;
      if (load_operand) operand_reg <= tok_data;
      if (load_op)      op_reg      <= tok_op;
      if (state_reg == S_EXEC) result_reg <= alu_y;
      // A fresh error takes priority over a simultaneous clear.
      if (err_set) begin
        err_reg      <= 1'b1;
        err_code_reg <= err_code_set;
      end else if (clr_err) begin
        err_reg      <= 1'b0;
        err_code_reg <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_rpn_ctrl.sv
// Self-checking bench for rpn_ctrl with a behavioural operand stack and a
// result scoreboard drained by an independent monitor.
module tb_rpn_ctrl;
  import calc_pkg::*;

  localparam int W     = 36;
  localparam int DEPTH = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tok_valid = 1'b0;
  logic         tok_ready;
  logic         tok_is_op = 1'b0;
  logic [1:0]   tok_op = 2'b00;
  logic [W-1:0] tok_data = '0;
  logic [W-1:0] stk_d;
  logic         stk_push;
  logic         stk_pop;
  logic [W-1:0] stk_q1;
  logic [W-1:0] stk_q2;
  logic [9:0]   stk_ptr;
  logic [W-1:0] result;
  logic         result_valid;
  logic         err;
  logic [1:0]   err_code;
  logic         clr_err = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  rpn_ctrl #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_is_op    (tok_is_op),
    .tok_op       (tok_op),
    .tok_data     (tok_data),
    .stk_d        (stk_d),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_q1       (stk_q1),
    .stk_q2       (stk_q2),
    .stk_ptr      (stk_ptr),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .err_code     (err_code),
    .clr_err      (clr_err)
  );

  // Behavioural stack: a pop removes two entries and presents them next cycle.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stk_ptr <= '0;
      stk_q1  <= '0;
      stk_q2  <= '0;
    end else if (stk_push && stk_ptr < 10'(DEPTH)) begin
      mem[stk_ptr] <= stk_d;
      stk_ptr      <= stk_ptr + 10'd1;
    end else if (stk_pop && stk_ptr >= 10'd2) begin
      stk_q1  <= mem[stk_ptr - 10'd1];
      stk_q2  <= mem[stk_ptr - 10'd2];
      stk_ptr <= stk_ptr - 10'd2;
    end
  end

  function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(expv));
    end else begin
      $display("ok   %s = %0d", nm, $signed(act));
    end
  endfunction

  // Monitor: pops an expected result whenever the DUT reports one.
  always @(negedge clk) begin
    if (stk_push && stk_pop) chk("push_pop_exclusive", 1, 0);
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got %0d expected no result", $signed(result));
      end else begin
        chk("result", result, exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle(input string nm);
    int guard = 0;
    @(negedge clk);
    while (!tok_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk({nm, "_ready_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tok_ready", W'(tok_ready), 1);
    chk("rst_stk_ptr", W'(stk_ptr), 0);
    chk("rst_err", W'({err, err_code}), 0);
  endtask

  // kind: 0 operand, 1 operator with result, 2 error token, 3 operator (result discarded)
  task automatic send(input logic is_op, input logic [1:0] op, input logic [W-1:0] data,
                      input int kind, input logic [W-1:0] exp_val,
                      input logic [1:0] exp_code, input string nm);
    wait_idle(nm);
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_op    = op;
    tok_data  = data;
    if (kind == 1) exp_q.push_back(exp_val);
    @(posedge clk);
    #1 tok_valid = 1'b0;
    @(negedge clk);
    case (kind)
      0: begin
        chk({nm, "_push"}, W'(stk_push), 1);
        chk({nm, "_stk_d"}, stk_d, data);
      end
      1, 3: chk({nm, "_pop"}, W'({stk_pop, stk_push}), 2);
      default: begin
        chk({nm, "_err"}, W'({err, err_code}), W'({1'b1, exp_code}));
        chk({nm, "_no_stack_op"}, W'({stk_push, stk_pop}), 0);
        chk({nm, "_ready_next"}, W'(tok_ready), 1);
      end
    endcase
  endtask

  initial begin
    // 1: 7 5 SUB -> 2
    do_reset();
    send(0, 2'b00, W'(7), 0, '0, 2'b00, "t1_op7");
    send(0, 2'b00, W'(5), 0, '0, 2'b00, "t1_op5");
    send(1, OP_SUB, '0, 1, W'(2), 2'b00, "t1_sub");
    wait_idle("t1_end");
    chk("t1_ptr", W'(stk_ptr), 1);

    // 2: -3 4 MUL 10 ADD -> -12, -2
    do_reset();
    send(0, 2'b00, W'(-3), 0, '0, 2'b00, "t2_m3");
    send(0, 2'b00, W'(4), 0, '0, 2'b00, "t2_4");
    send(1, OP_MUL, '0, 1, W'(-12), 2'b00, "t2_mul");
    send(0, 2'b00, W'(10), 0, '0, 2'b00, "t2_10");
    send(1, OP_ADD, '0, 1, W'(-2), 2'b00, "t2_add");
    wait_idle("t2_end");
    chk("t2_ptr", W'(stk_ptr), 1);

    // 3: 9 ADD -> underflow, then clear
    do_reset();
    send(0, 2'b00, W'(9), 0, '0, 2'b00, "t3_9");
    send(1, OP_ADD, '0, 2, '0, ERR_UNDER, "t3_add");
    chk("t3_ptr", W'(stk_ptr), 1);
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    @(negedge clk);
    chk("t3_cleared", W'({err, err_code}), 0);

    // 4: fill stack, overflow, then SUB of top two (8 - 9)
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++)
      send(0, 2'b00, W'(i + 1), 0, '0, 2'b00, "t4_fill");
    send(0, 2'b00, W'(99), 2, '0, ERR_OVER, "t4_over");
    chk("t4_ptr_full", W'(stk_ptr), DEPTH - 1);
    send(1, OP_SUB, '0, 1, W'(-1), 2'b00, "t4_sub");
    wait_idle("t4_end");
    chk("t4_ptr", W'(stk_ptr), DEPTH - 2);

    // 5: illegal opcode with simultaneous clr_err; error must win
    clr_err = 1'b1;
    send(1, OP_ILL, '0, 2, '0, ERR_ILL, "t5_ill");
    clr_err = 1'b0;
    chk("t5_ptr", W'(stk_ptr), DEPTH - 2);

    // 6: reset during EXEC of 2 3 ADD
    do_reset();
    send(0, 2'b00, W'(2), 0, '0, 2'b00, "t6_2");
    send(0, 2'b00, W'(3), 0, '0, 2'b00, "t6_3");
    send(1, OP_ADD, '0, 3, '0, 2'b00, "t6_add");
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("t6_outs_zero", W'({stk_push, stk_pop, result_valid, tok_ready, err, err_code}), 0);
    chk("t6_result_zero", result, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_ready", W'(tok_ready), 1);
    chk("t6_ptr", W'(stk_ptr), 0);

    repeat (10) @(negedge clk);
    chk("results_drained", W'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
